// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the video raster generator: mode sets,
// stream FSM encoding and counter width.
package video_timing_pkg;

   localparam int unsigned CNT_W = 12;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   typedef struct packed {
      axis_timing_t h;
      axis_timing_t v;
   } video_mode_t;

   localparam video_mode_t MODE_640X480_60 = '{
      h: '{640, 16, 96, 48},
      v: '{480, 10, 2, 33}
   };

   localparam video_mode_t MODE_1280X720_60 = '{
      h: '{1280, 110, 40, 220},
      v: '{720, 5, 5, 20}
   };

   typedef enum logic {
      StSeek = 1'b0,
      StLock = 1'b1
   } stream_state_e;

   function automatic int unsigned axis_total(axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters (hc/vc) with active, sync and origin decode.
module video_timing_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = MODE_640X480_60.h.active,
   parameter int unsigned H_FP     = MODE_640X480_60.h.fp,
   parameter int unsigned H_SYNC   = MODE_640X480_60.h.sync,
   parameter int unsigned H_BP     = MODE_640X480_60.h.bp,
   parameter int unsigned V_ACTIVE = MODE_640X480_60.v.active,
   parameter int unsigned V_FP     = MODE_640X480_60.v.fp,
   parameter int unsigned V_SYNC   = MODE_640X480_60.v.sync,
   parameter int unsigned V_BP     = MODE_640X480_60.v.bp
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic active,
   output logic hsync_act,
   output logic vsync_act,
   output logic origin
);

   localparam axis_timing_t H_TIM = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
   localparam axis_timing_t V_TIM = '{V_ACTIVE, V_FP, V_SYNC, V_BP};

   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(axis_total(H_TIM) - 1);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(axis_total(V_TIM) - 1);

   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;

   // Disabled raster parks at the origin so the first enabled cycle is (0,0).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hc <= '0;
         vc <= '0;
      end else if (!en) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   always_comb begin
      active    = (hc < H_ACT) && (vc < V_ACT);
      hsync_act = (hc >= H_SS) && (hc < H_SE);
      vsync_act = (vc >= V_SS) && (vc < V_SE);
      origin    = (hc == '0) && (vc == '0);
   end

endmodule

// File: rtl/video_stream_timing.sv
// Video timing generator that locks a valid/ready pixel stream to the raster,
// filling underflow and framing-error slots with a background colour.
module video_stream_timing
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = MODE_640X480_60.h.active,
   parameter int unsigned H_FP     = MODE_640X480_60.h.fp,
   parameter int unsigned H_SYNC   = MODE_640X480_60.h.sync,
   parameter int unsigned H_BP     = MODE_640X480_60.h.bp,
   parameter int unsigned V_ACTIVE = MODE_640X480_60.v.active,
   parameter int unsigned V_FP     = MODE_640X480_60.v.fp,
   parameter int unsigned V_SYNC   = MODE_640X480_60.v.sync,
   parameter int unsigned V_BP     = MODE_640X480_60.v.bp,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0,
   parameter logic [23:0] BG_COLOR = 24'h000000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic [23:0] s_data,
   input  logic        s_valid,
   input  logic        s_sof,
   output logic        s_ready,
   output logic [23:0] video_din,
   output logic        video_hsync,
   output logic        video_vsync,
   output logic        video_de,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_err
);

   logic          active;
   logic          hsync_act;
   logic          vsync_act;
   logic          origin;
   stream_state_e state;

   video_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_counter (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .active    (active),
      .hsync_act (hsync_act),
      .vsync_act (vsync_act),
      .origin    (origin)
   );

   // SEEK drains non-sof beats freely but parks a sof beat until the origin.
   always_comb begin
      s_ready = 1'b0;
      if (rstn && en) begin
         if (state == StSeek) begin
            s_ready = !s_sof || origin;
         end else begin
            s_ready = active;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= StSeek;
         video_din   <= '0;
         video_de    <= 1'b0;
         video_hsync <= ~HS_POL;
         video_vsync <= ~VS_POL;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
      end else if (!en) begin
         state       <= StSeek;
         video_din   <= '0;
         video_de    <= 1'b0;
         video_hsync <= ~HS_POL;
         video_vsync <= ~VS_POL;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         video_de    <= active;
         video_hsync <= hsync_act ? HS_POL : ~HS_POL;
         video_vsync <= vsync_act ? VS_POL : ~VS_POL;
         frame_start <= origin;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
         video_din   <= active ? BG_COLOR : '0;
         unique case (state)
            StSeek: begin
               if (s_valid && s_sof && origin) begin
                  video_din <= s_data;
                  state     <= StLock;
               end
            end
            StLock: begin
               if (active) begin
                  if (!s_valid) begin
                     underflow <= 1'b1;
                  end else if (s_sof != origin) begin
                     sync_err <= 1'b1;
                     state    <= StSeek;
                  end else begin
                     video_din <= s_data;
                  end
               end
            end
         endcase
      end
   end

endmodule
